// File: rtl/sqrt_arbiter_pkg.sv
// Shared definitions for arbiters that time-share the iterative sqrt primitive.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Cycles the sqrt unit needs from go to done.
    localparam int SQRT_LAT = 18;
    // A done seen before this many BUSY cycles is a leftover from an earlier job.
    localparam int DONE_GUARD = 2;

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible bit at or above ptr_i, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum > N_REQ - 1) sum = sum - N_REQ;
        return IDX_W'(sum);
    endfunction

    logic [IDX_W-1:0] cand;

    // Scan from the far end so the candidate closest to ptr_i is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = wrap_add(ptr_i, off);
            if (eligible_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin scheduler sharing one iterative sqrt unit among N_REQ go/done requesters.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_go,
    input  logic [N_REQ*WIDTH-1:0] req_in,
    output logic [WIDTH-1:0]       resp_out,
    output logic [N_REQ-1:0]       resp_done,
    output logic                   resp_err,
    output logic                   busy,
    output logic [WIDTH-1:0]       sqrt_in,
    output logic                   sqrt_go,
    input  logic [WIDTH-1:0]       sqrt_out,
    input  logic                   sqrt_done
);

    localparam int         IDX_W    = $clog2(N_REQ);
    localparam logic [4:0] CYC_LAST = 5'(TIMEOUT - 1);
    localparam logic [4:0] CYC_MIN  = 5'(DONE_GUARD);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   mask_q, mask_d;
    logic [4:0]         cyc_q, cyc_d;
    logic [WIDTH-1:0]   sqrt_in_q, sqrt_in_d;
    logic               sqrt_go_q, sqrt_go_d;
    logic [WIDTH-1:0]   resp_out_q, resp_out_d;
    logic [N_REQ-1:0]   resp_done_q, resp_done_d;
    logic               resp_err_q, resp_err_d;

    logic [WIDTH-1:0]   opnd [N_REQ];
    logic [N_REQ-1:0]   grant_oh;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_opnd
        assign opnd[k] = req_in[k*WIDTH +: WIDTH];
    end

    assign grant_oh = N_REQ'(1) << grant_q;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .eligible_i (req_go & ~mask_q),
        .ptr_i      (rr_ptr_q),
        .valid_o    (pick_vld),
        .idx_o      (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        mask_d      = mask_q;
        cyc_d       = cyc_q;
        sqrt_in_d   = sqrt_in_q;
        sqrt_go_d   = sqrt_go_q;
        resp_out_d  = resp_out_q;
        resp_done_d = '0;
        resp_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (pick_vld) begin
                    grant_d   = pick_idx;
                    sqrt_in_d = opnd[pick_idx];
                    sqrt_go_d = 1'b1;
                    cyc_d     = '0;
                    rr_ptr_d  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cyc_d = cyc_q + 5'd1;
                if (sqrt_done && (cyc_q >= CYC_MIN)) begin
                    resp_out_d  = sqrt_out;
                    resp_done_d = grant_oh;
                    sqrt_go_d   = 1'b0;
                    state_d     = DONE;
                end else if (cyc_q == CYC_LAST) begin
                    resp_out_d  = '0;
                    resp_err_d  = 1'b1;
                    resp_done_d = grant_oh;
                    sqrt_go_d   = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Hide the just-served requester for one IDLE cycle so a late-dropping go is not re-issued.
                mask_d  = grant_oh;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            mask_q      <= '0;
            cyc_q       <= '0;
            sqrt_in_q   <= '0;
            sqrt_go_q   <= 1'b0;
            resp_out_q  <= '0;
            resp_done_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            mask_q      <= mask_d;
            cyc_q       <= cyc_d;
            sqrt_in_q   <= sqrt_in_d;
            sqrt_go_q   <= sqrt_go_d;
            resp_out_q  <= resp_out_d;
            resp_done_q <= resp_done_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign sqrt_in   = sqrt_in_q;
    assign sqrt_go   = sqrt_go_q;
    assign resp_out  = resp_out_q;
    assign resp_done = resp_done_q;
    assign resp_err  = resp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt unit, directed scenarios and a randomized job-level reference model.
module tb_sqrt_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 24;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_go = '0;
    logic [N*W-1:0] req_in = '0;
    logic [W-1:0]   resp_out, sqrt_in, sqrt_out;
    logic [N-1:0]   resp_done;
    logic           resp_err, busy, sqrt_go, sqrt_done;

    logic        hold_done = 1'b0;
    logic        stale_done = 1'b0;
    int unsigned scnt = 0;

    sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_go    (req_go),
        .req_in    (req_in),
        .resp_out  (resp_out),
        .resp_done (resp_done),
        .resp_err  (resp_err),
        .busy      (busy),
        .sqrt_in   (sqrt_in),
        .sqrt_go   (sqrt_go),
        .sqrt_out  (sqrt_out),
        .sqrt_done (sqrt_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        longint unsigned r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[W-1:0];
    endfunction

    // Iterative sqrt unit: counts while go is held, done after 18 go cycles.
    always @(posedge clk) scnt <= sqrt_go ? scnt + 1 : 0;
    assign sqrt_done = (sqrt_go && scnt == 18 && !hold_done) || stale_done;
    assign sqrt_out  = isqrt(sqrt_in);

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [63:0] go_tr = '0, done_tr = '0, err_tr = '0;

    typedef struct {
        int           rel;
        logic [N-1:0] idx;
        logic [W-1:0] val;
        logic         err;
    } done_rec_t;
    done_rec_t done_q[$];

    logic [N-1:0] late = '0;
    int drop_at [N];
    int last_low [N];

    bit             model_en = 1'b0;
    bit             mbusy = 1'b0;
    int             free_from = 0, mdone = 0, mk = 0, mptr = 0, n_rnd_done = 0;
    logic [N-1:0]   lastmask = '0;
    logic [W-1:0]   mop = '0;
    logic [N-1:0]   snap_go = '0;
    logic [N*W-1:0] snap_in = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] elig, input int ptr);
        for (int i = 0; i < N; i++)
            if (elig[(ptr + i) % N]) return (ptr + i) % N;
        return 0;
    endfunction

    // Job-level model: an idle arbiter grants the round-robin winner among requesters
    // (the one served last is invisible in its first idle cycle); reply 20 cycles after grant.
    task automatic model_step();
        int p;
        logic [N-1:0] elig;
        p = cyc - 1;
        if (!mbusy && p >= free_from) begin
            elig = snap_go & ~((p == free_from) ? lastmask : '0);
            if (elig != '0) begin
                mk    = rr_ref(elig, mptr);
                mop   = snap_in[mk*W +: W];
                mbusy = 1'b1;
                mdone = p + 20;
                mptr  = (mk + 1) % N;
                check_eq("rnd_grant_go", 64'(sqrt_go), 64'd1);
                check_eq("rnd_grant_opnd", 64'(sqrt_in), 64'(mop));
            end else begin
                check_eq("rnd_idle_go", 64'(sqrt_go), 64'd0);
            end
        end
        if (mbusy && cyc == mdone) begin
            check_eq("rnd_done_idx", 64'(resp_done), 64'd1 << mk);
            check_eq("rnd_done_val", 64'(resp_out), 64'(isqrt(mop)));
            check_eq("rnd_done_err", 64'(resp_err), 64'd0);
            mbusy     = 1'b0;
            free_from = cyc + 1;
            lastmask  = N'(1) << mk;
            n_rnd_done++;
        end else begin
            check_eq("rnd_no_done", 64'(resp_done), 64'd0);
        end
    endtask

    task automatic tick();
        int rel;
        done_rec_t r;
        snap_go = req_go;
        snap_in = req_in;
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            go_tr[6'(rel)]   = sqrt_go;
            done_tr[6'(rel)] = |resp_done;
            err_tr[6'(rel)]  = resp_err;
        end
        if (resp_done !== '0) begin
            r.rel = rel; r.idx = resp_done; r.val = resp_out; r.err = resp_err;
            done_q.push_back(r);
        end
        if (model_en) model_step();
        for (int j = 0; j < N; j++) begin
            if (drop_at[j] == cyc) begin
                req_go[j]   = 1'b0;
                last_low[j] = cyc;
            end
            if (resp_done[j] === 1'b1) begin
                if (late[j]) drop_at[j] = cyc + 2;
                else begin
                    req_go[j]   = 1'b0;
                    last_low[j] = cyc;
                end
            end
        end
    endtask

    task automatic set_req(input int k, input logic [W-1:0] op);
        req_in[k*W +: W] = op;
        req_go[k] = 1'b1;
    endtask

    task automatic start_window();
        t0 = cyc;
        go_tr = '0; done_tr = '0; err_tr = '0;
        done_q.delete();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_go = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_done(input string tag, input int i, input int rel,
                              input logic [N-1:0] idx, input logic [W-1:0] val, input logic err);
        if (done_q.size() <= i) begin
            check_eq({tag, "_present"}, 64'(done_q.size()), 64'(i + 1));
        end else begin
            check_eq({tag, "_cycle"}, 64'(done_q[i].rel), 64'(rel));
            check_eq({tag, "_idx"},   64'(done_q[i].idx), 64'(idx));
            check_eq({tag, "_val"},   64'(done_q[i].val), 64'(val));
            check_eq({tag, "_err"},   64'(done_q[i].err), 64'(err));
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            drop_at[j]  = -1;
            last_low[j] = -1;
        end

        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_sqrt_go",   64'(sqrt_go),   64'd0);
        check_eq("rst_sqrt_in",   64'(sqrt_in),   64'd0);
        check_eq("rst_resp_out",  64'(resp_out),  64'd0);
        check_eq("rst_resp_done", 64'(resp_done), 64'd0);
        check_eq("rst_resp_err",  64'(resp_err),  64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        reset = 1'b0;

        // Single request: sqrt(144) on requester 2.
        start_window();
        set_req(2, 32'd144);
        repeat (24) tick();
        check_eq("single_go_trace",   go_tr,   64'h000F_FFFE);
        check_eq("single_done_trace", done_tr, 64'd1 << 20);
        check_done("single", 0, 20, 4'b0100, 32'd12, 1'b0);
        check_eq("single_busy_end", 64'(busy), 64'd0);

        // All four from reset, served 0,1,2,3 every 21 cycles.
        do_reset();
        start_window();
        set_req(0, 32'd0);
        set_req(1, 32'd1);
        set_req(2, 32'hFFFF_FFFF);
        set_req(3, 32'd1000000);
        repeat (90) tick();
        check_eq("all4_count", 64'(done_q.size()), 64'd4);
        check_done("all4_r0", 0, 20, 4'b0001, 32'd0,     1'b0);
        check_done("all4_r1", 1, 41, 4'b0010, 32'd1,     1'b0);
        check_done("all4_r2", 2, 62, 4'b0100, 32'd65535, 1'b0);
        check_done("all4_r3", 3, 83, 4'b1000, 32'd1000,  1'b0);

        // Fairness: after serving 2, requester 3 goes before 0.
        start_window();
        set_req(2, 32'd16);
        repeat (5) tick();
        set_req(0, 32'd49);
        set_req(3, 32'd64);
        repeat (70) tick();
        check_done("fair_first",  0, 20, 4'b0100, 32'd4, 1'b0);
        check_done("fair_second", 1, 41, 4'b1000, 32'd8, 1'b0);
        check_done("fair_third",  2, 62, 4'b0001, 32'd7, 1'b0);

        // Late go drop must not re-issue.
        late[1] = 1'b1;
        start_window();
        set_req(1, 32'd25);
        repeat (30) tick();
        check_eq("late_go_trace",   go_tr,   64'h000F_FFFE);
        check_eq("late_done_trace", done_tr, 64'd1 << 20);
        check_eq("late_count", 64'(done_q.size()), 64'd1);
        check_done("late", 0, 20, 4'b0010, 32'd5, 1'b0);
        late[1] = 1'b0;

        // Timeout with a silent sqrt unit, then normal service.
        hold_done = 1'b1;
        start_window();
        set_req(0, 32'd100);
        repeat (30) tick();
        check_eq("tmo_go_trace",   go_tr,   64'h01FF_FFFE);
        check_eq("tmo_done_trace", done_tr, 64'd1 << 25);
        check_eq("tmo_err_trace",  err_tr,  64'd1 << 25);
        check_done("tmo", 0, 25, 4'b0001, 32'd0, 1'b1);
        hold_done = 1'b0;
        start_window();
        set_req(3, 32'd36);
        repeat (25) tick();
        check_eq("post_tmo_count", 64'(done_q.size()), 64'd1);
        check_done("post_tmo", 0, 20, 4'b1000, 32'd6, 1'b0);

        // Reset mid-job, then a new job with a stale done in its first BUSY cycles.
        start_window();
        set_req(2, 32'd400);
        repeat (10) tick();
        reset  = 1'b1;
        req_go = '0;
        tick();
        check_eq("midrst_sqrt_go", 64'(sqrt_go),   64'd0);
        check_eq("midrst_busy",    64'(busy),      64'd0);
        check_eq("midrst_done",    64'(resp_done), 64'd0);
        reset = 1'b0;
        repeat (25) tick();
        check_eq("midrst_no_done", 64'(done_q.size()), 64'd0);
        start_window();
        set_req(1, 32'd81);
        tick();
        stale_done = 1'b1;
        tick();
        tick();
        stale_done = 1'b0;
        repeat (22) tick();
        check_eq("stale_done_trace", done_tr, 64'd1 << 20);
        check_eq("stale_count", 64'(done_q.size()), 64'd1);
        check_done("stale", 0, 20, 4'b0010, 32'd9, 1'b0);

        // Randomized traffic against the job-level model.
        do_reset();
        for (int j = 0; j < N; j++) begin
            late[j]     = 1'($urandom_range(0, 1));
            drop_at[j]  = -1;
            last_low[j] = -1;
        end
        mbusy = 1'b0; free_from = cyc; mptr = 0; lastmask = '0; n_rnd_done = 0;
        model_en = 1'b1;
        for (int c = 0; c < 700; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!req_go[j] && drop_at[j] < cyc && last_low[j] < cyc && $urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 5))
                        0:       set_req(j, 32'd0);
                        1:       set_req(j, 32'hFFFF_FFFF);
                        2:       set_req(j, 32'($urandom_range(0, 300)));
                        default: set_req(j, 32'($urandom));
                    endcase
                end
            end
            tick();
        end
        for (int c = 0; c < 200 && (mbusy || req_go != '0); c++) tick();
        check_eq("rnd_drained", {63'd0, mbusy} | 64'(req_go), 64'd0);
        check_eq("rnd_enough_jobs", 64'(n_rnd_done > 10), 64'd1);
        model_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
